// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM encodings and default width for the HI/LO unit
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [3:0] {
    NOP   = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MTHI  = 4'd5,
    MTLO  = 4'd6,
    MFHI  = 4'd7,
    MFLO  = 4'd8
  } muldiv_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mul_pipe.sv
// rtl/mul_pipe.sv - WIDTH x WIDTH -> 2*WIDTH multiplier; HI/LO capture in the parent is the last stage
module mul_pipe #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 valid_in,
  output logic [2*WIDTH-1:0]   product,
  output logic                 valid_out
);

  localparam int STAGES = MUL_LAT - 1;

  logic [2*WIDTH-1:0] a_ext, b_ext, prod_raw;

  // Low 2*WIDTH bits of the extended product are correct for both signed and unsigned
  always_comb begin
    a_ext    = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
    b_ext    = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
    prod_raw = a_ext * b_ext;
  end

  generate
    if (STAGES == 0) begin : g_comb
      assign product   = prod_raw;
      assign valid_out = valid_in;
    end else begin : g_pipe
      logic [2*WIDTH-1:0] prod_d [STAGES];
      logic [2*WIDTH-1:0] prod_q [STAGES];
      logic [STAGES-1:0]  vld_d, vld_q;

      always_comb begin
        prod_d[0] = prod_raw;
        vld_d[0]  = valid_in;
        for (int i = 1; i < STAGES; i++) begin
          prod_d[i] = prod_q[i-1];
          vld_d[i]  = vld_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
        prod_q <= prod_d;
      end

      assign product   = prod_q[STAGES-1];
      assign valid_out = vld_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - EX-stage HI/LO sequencer: multiplier pipe, divider handshake, HI/LO registers
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [3:0]           ex_op,
  input  logic [WIDTH-1:0]     ex_a,
  input  logic [WIDTH-1:0]     ex_b,
  input  logic                 pipe_stall,
  input  logic                 flush,
  output logic                 stall_req,
  output logic [WIDTH-1:0]     mf_data,
  output logic [WIDTH-1:0]     hi_o,
  output logic [WIDTH-1:0]     lo_o,
  output logic                 div_start,
  output logic                 div_signed,
  output logic [WIDTH-1:0]     div_a,
  output logic [WIDTH-1:0]     div_b,
  output logic                 div_enable,
  output logic                 div_annul,
  input  logic [2*WIDTH-1:0]   div_result,
  input  logic                 div_ready
);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   div_a_q, div_a_d, div_b_q, div_b_d;
  logic               div_start_q, div_start_d, div_signed_q, div_signed_d;
  logic               go, is_mul, is_div, mul_vout;
  logic [2*WIDTH-1:0] mul_prod;

  always_comb begin
    go     = ex_valid & ~flush & (state_q == ST_IDLE);
    is_mul = (ex_op == MULT) || (ex_op == MULTU);
    is_div = (ex_op == DIV) || (ex_op == DIVU);
  end

  // Flush also clears the pipe so a killed product can never complete a later MULT
  mul_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) u_mul_pipe (
    .clk       (clk),
    .rst       (rst | flush),
    .is_signed (ex_op == MULT),
    .a         (ex_a),
    .b         (ex_b),
    .valid_in  (go & is_mul),
    .product   (mul_prod),
    .valid_out (mul_vout)
  );

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    div_start_d  = div_start_q;
    div_signed_d = div_signed_q;
    stall_req    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          if (is_mul) begin
            stall_req = 1'b1;
            state_d   = ST_MUL;
            if (mul_vout) begin
              {hi_d, lo_d} = mul_prod;
              state_d      = ST_DONE;
            end
          end else if (is_div && (ex_b != '0)) begin
            stall_req    = 1'b1;
            state_d      = ST_DIV;
            div_start_d  = 1'b1;
            div_signed_d = (ex_op == DIV);
            div_a_d      = ex_a;
            div_b_d      = ex_b;
          end else if (!pipe_stall && (ex_op == MTHI)) begin
            hi_d = ex_a;
          end else if (!pipe_stall && (ex_op == MTLO)) begin
            lo_d = ex_a;
          end
        end
      end
      ST_MUL: begin
        stall_req = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mul_vout) begin
          {hi_d, lo_d} = mul_prod;
          state_d      = ST_DONE;
        end
      end
      ST_DIV: begin
        stall_req = 1'b1;
        if (flush) begin
          state_d     = ST_IDLE;
          div_start_d = 1'b0;
        end else if (div_ready) begin
          hi_d        = div_result[2*WIDTH-1:WIDTH];
          lo_d        = div_result[WIDTH-1:0];
          div_start_d = 1'b0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        // The finished op is still sitting in EX; leave only once it moves on
        if (flush || !pipe_stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mf_data = '0;
    if (ex_valid && (ex_op == MFHI)) mf_data = hi_q;
    else if (ex_valid && (ex_op == MFLO)) mf_data = lo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      div_start_q  <= 1'b0;
      div_signed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      div_start_q  <= div_start_d;
      div_signed_q <= div_signed_d;
    end
  end

  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_start  = div_start_q;
  assign div_signed = div_signed_q;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign div_enable = ~pipe_stall;
  assign div_annul  = flush;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - randomized and directed checks of hilo_muldiv_ctrl against a reference model
module tb_hilo_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W       = 32;
  localparam int MUL_LAT = 2;
  localparam int DIV_CYC = 7;

  logic           clk = 1'b0;
  logic           rst, ex_valid, pipe_stall, flush;
  logic [3:0]     ex_op;
  logic [W-1:0]   ex_a, ex_b;
  logic           stall_req, div_start, div_signed, div_enable, div_annul, div_ready;
  logic [W-1:0]   mf_data, hi_o, lo_o, div_a, div_b;
  logic [2*W-1:0] div_result;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;
  int div_cnt = 0;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(.WIDTH(W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
    .pipe_stall(pipe_stall), .flush(flush), .stall_req(stall_req), .mf_data(mf_data),
    .hi_o(hi_o), .lo_o(lo_o), .div_start(div_start), .div_signed(div_signed),
    .div_a(div_a), .div_b(div_b), .div_enable(div_enable), .div_annul(div_annul),
    .div_result(div_result), .div_ready(div_ready)
  );

  // Behavioural iterative divider: ready DIV_CYC enabled cycles after start rises
  always @(posedge clk) begin
    if (rst || !div_start || div_annul) div_cnt <= 0;
    else if (div_enable && div_cnt < DIV_CYC) div_cnt <= div_cnt + 1;
  end

  always_comb begin
    div_ready  = div_start && (div_cnt == DIV_CYC);
    div_result = '0;
    if (div_b != '0) begin
      if (div_signed) div_result = {$signed(div_a) % $signed(div_b), $signed(div_a) / $signed(div_b)};
      else            div_result = {div_a % div_b, div_a / div_b};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] exp_hi, exp_lo, exp_mf;
    logic signed [W-1:0] sa, sb;
    logic signed [2*W-1:0] sa64, sb64;
    int exp_stall, exp_start, stalls, starts;
    exp_hi = hi_m; exp_lo = lo_m; exp_mf = '0; exp_stall = 0; exp_start = 0;
    sa = a; sb = b; sa64 = sa; sb64 = sb;
    case (op)
      MULT:  begin {exp_hi, exp_lo} = sa64 * sb64; exp_stall = MUL_LAT; end
      MULTU: begin {exp_hi, exp_lo} = {32'b0, a} * {32'b0, b}; exp_stall = MUL_LAT; end
      DIV:   if (b != '0) begin exp_lo = sa / sb; exp_hi = sa % sb; exp_stall = DIV_CYC + 2; exp_start = DIV_CYC + 1; end
      DIVU:  if (b != '0) begin exp_lo = a / b; exp_hi = a % b; exp_stall = DIV_CYC + 2; exp_start = DIV_CYC + 1; end
      MTHI:  exp_hi = a;
      MTLO:  exp_lo = a;
      MFHI:  exp_mf = hi_m;
      MFLO:  exp_mf = lo_m;
      default: ;
    endcase
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = op; ex_a = a; ex_b = b;
    @(negedge clk);
    n_vec++; if (mf_data !== exp_mf) begin n_err++; $display("FAIL mf_data op=%0d: got %h want %h", op, mf_data, exp_mf); end
    stalls = 0; starts = 0;
    while (stall_req === 1'b1 && stalls < 200) begin
      stalls++;
      if (div_start === 1'b1) starts++;
      @(negedge clk);
    end
    n_vec++; if (stalls != exp_stall) begin n_err++; $display("FAIL stall_cycles op=%0d: got %0d want %0d", op, stalls, exp_stall); end
    n_vec++; if (starts != exp_start) begin n_err++; $display("FAIL div_start_cycles op=%0d: got %0d want %0d", op, starts, exp_start); end
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = NOP;
    @(negedge clk);
    n_vec++; if (hi_o !== exp_hi) begin n_err++; $display("FAIL hi op=%0d a=%h b=%h: got %h want %h", op, a, b, hi_o, exp_hi); end
    n_vec++; if (lo_o !== exp_lo) begin n_err++; $display("FAIL lo op=%0d a=%h b=%h: got %h want %h", op, a, b, lo_o, exp_lo); end
    n_vec++; if (stall_req !== 1'b0 || div_start !== 1'b0) begin n_err++; $display("FAIL idle_after op=%0d: got stall=%b start=%b want 0 0", op, stall_req, div_start); end
    if ((op == DIV || op == DIVU) && b != '0) begin
      n_vec++;
      if (div_a !== a || div_b !== b || div_signed !== (op == DIV)) begin
        n_err++; $display("FAIL div_operands: got %h %h %b want %h %h %b", div_a, div_b, div_signed, a, b, op == DIV);
      end
    end
    hi_m = exp_hi; lo_m = exp_lo;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b0; ex_op = NOP; ex_a = '0; ex_b = '0; pipe_stall = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if ({hi_o, lo_o} !== '0) begin n_err++; $display("FAIL reset_hilo: got %h want 0", {hi_o, lo_o}); end
    n_vec++; if ({stall_req, div_start, div_signed} !== 3'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 000", {stall_req, div_start, div_signed}); end
    n_vec++; if ({div_a, div_b, mf_data} !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", {div_a, div_b, mf_data}); end
    n_vec++; if (div_enable !== 1'b1 || div_annul !== 1'b0) begin n_err++; $display("FAIL reset_div_hs: got en=%b annul=%b want 1 0", div_enable, div_annul); end
    @(posedge clk); #1 rst = 1'b0;
    hi_m = '0; lo_m = '0;
  endtask

  task automatic test_directed();
    run_op(MULT, 32'hFFFF_FFFD, 32'd7);
    run_op(MULTU, 32'hFFFF_FFFF, 32'd2);
    run_op(DIV, 32'hFFFF_FFF9, 32'd2);
    run_op(DIVU, 32'd100, 32'd0);
    run_op(DIVU, 32'd100, 32'd7);
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] p;
    int stalls;
    p = {32'b0, 32'hFFFF_FFFF} * {32'b0, 32'd2};
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = MULTU; ex_a = 32'hFFFF_FFFF; ex_b = 32'd2;
    @(negedge clk);
    stalls = 0;
    while (stall_req === 1'b1 && stalls < 50) begin stalls++; @(negedge clk); end
    n_vec++; if (stalls != MUL_LAT) begin n_err++; $display("FAIL b2b_stall: got %0d want %0d", stalls, MUL_LAT); end
    @(posedge clk); #1;
    ex_op = MFHI; ex_a = '0; ex_b = '0;
    @(negedge clk);
    n_vec++; if (mf_data !== p[2*W-1:W]) begin n_err++; $display("FAIL b2b_mfhi: got %h want %h", mf_data, p[2*W-1:W]); end
    n_vec++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL b2b_mf_stall: got %b want 0", stall_req); end
    @(posedge clk); #1;
    ex_op = MFLO;
    @(negedge clk);
    n_vec++; if (mf_data !== p[W-1:0]) begin n_err++; $display("FAIL b2b_mflo: got %h want %h", mf_data, p[W-1:0]); end
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = NOP;
    hi_m = p[2*W-1:W]; lo_m = p[W-1:0];
    @(negedge clk);
    n_vec++; if ({hi_o, lo_o} !== p) begin n_err++; $display("FAIL b2b_no_reissue: got %h want %h", {hi_o, lo_o}, p); end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = DIV; ex_a = 32'hFFFF_FFF9; ex_b = 32'd2;
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1; ex_valid = 1'b0; ex_op = NOP;
    @(negedge clk);
    n_vec++; if (div_annul !== 1'b1) begin n_err++; $display("FAIL flush_annul: got %b want 1", div_annul); end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    n_vec++; if (stall_req !== 1'b0 || div_start !== 1'b0) begin n_err++; $display("FAIL flush_idle: got stall=%b start=%b want 0 0", stall_req, div_start); end
    n_vec++; if (hi_o !== hi_m || lo_o !== lo_m) begin n_err++; $display("FAIL flush_hilo: got %h %h want %h %h", hi_o, lo_o, hi_m, lo_m); end
    run_op(MTLO, 32'h55, '0);
  endtask

  task automatic test_mthi_stall();
    run_op(MTHI, 32'hA5A5_A5A5, '0);
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = MTHI; ex_a = 32'h1234; pipe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin @(posedge clk); #1 pipe_stall = 1'b0; end
      else if (i == 1) begin @(posedge clk); #1; end
      @(negedge clk);
      n_vec++; if (hi_o !== hi_m) begin n_err++; $display("FAIL mthi_held cyc=%0d: got %h want %h", i, hi_o, hi_m); end
      n_vec++; if (div_enable !== ~pipe_stall || stall_req !== 1'b0) begin n_err++; $display("FAIL mthi_hs cyc=%0d: got en=%b stall=%b want %b 0", i, div_enable, stall_req, ~pipe_stall); end
    end
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = NOP;
    @(negedge clk);
    n_vec++; if (hi_o !== 32'h1234) begin n_err++; $display("FAIL mthi_write: got %h want 00001234", hi_o); end
    hi_m = 32'h1234;
  endtask

  task automatic test_rst_mid();
    for (int k = 0; k < 2; k++) begin
      run_op(MTLO, 32'hDEAD_BEEF, '0);
      @(posedge clk); #1;
      ex_valid = 1'b1; ex_op = (k == 0) ? MULT : DIVU; ex_a = 32'd100; ex_b = 32'd7;
      repeat (k + 1) begin @(posedge clk); #1; end
      rst = 1'b1; ex_valid = 1'b0; ex_op = NOP;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_vec++; if ({hi_o, lo_o, div_a, div_b, mf_data} !== '0) begin n_err++; $display("FAIL rst_mid_data k=%0d: got %h %h %h %h want 0", k, hi_o, lo_o, div_a, div_b); end
      n_vec++; if ({stall_req, div_start, div_signed} !== 3'b0) begin n_err++; $display("FAIL rst_mid_ctrl k=%0d: got %b want 000", k, {stall_req, div_start, div_signed}); end
      hi_m = '0; lo_m = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++; if ({hi_o, lo_o} !== '0) begin n_err++; $display("FAIL rst_mid_late k=%0d: got %h want 0", k, {hi_o, lo_o}); end
    end
    run_op(MULT, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(1, 8));
      a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      b  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      if (op == DIV && b == 32'hFFFF_FFFF) b = 32'hFFFF_FFFE;
      run_op(op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_mthi_stall();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
